// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and load-op codes for the memory-access stage.
// The MEM_SUBWORD_LOAD_EN macro enables the byte/halfword load aligner.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 145;
    localparam int MEM_TO_WB_WD = 136;
    localparam int STALL_BUS_WD = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [2:0] MemOpLW  = 3'd0;
    localparam logic [2:0] MemOpLB  = 3'd1;
    localparam logic [2:0] MemOpLBU = 3'd2;
    localparam logic [2:0] MemOpLH  = 3'd3;
    localparam logic [2:0] MemOpLHU = 3'd4;

    // Field order matches the packed execute-to-memory bus, MSB first.
    typedef struct packed {
        logic [2:0]  mem_op;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef enum logic {
        FRESH = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Byte/halfword selection and sign/zero extension of SRAM load data.
// Only compiled when MEM_SUBWORD_LOAD_EN is defined.
`ifdef MEM_SUBWORD_LOAD_EN
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{addr, 3'b000} +: 8];
    assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: default assignment first so every path drives data and no latch is inferred.
    always_comb begin
        data = rdata;
        case (mem_op)
            MemOpLB:  data = {{24{byte_lane[7]}}, byte_lane};
            MemOpLBU: data = {24'h0, byte_lane};
            MemOpLH:  data = {{16{half_lane[15]}}, half_lane};
            MemOpLHU: data = {16'h0, half_lane};
            default:  data = rdata;
        endcase
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// MIPS memory-access stage: pipeline register, stall-safe read-data hold, load alignment.
// Define MEM_SUBWORD_LOAD_EN to enable LB/LBU/LH/LHU alignment; otherwise loads return the full word.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_BUS_WD-1:0]  stall,
    input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [37:0]              mem_to_id_fwd
);

    ex_to_mem_t  ex_to_mem_bus_r;
    hold_state_t state;
    logic [31:0] rdata_hold;
    logic [31:0] rdata;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
            state           <= FRESH;
            rdata_hold      <= '0;
        end else if (stall[3] == Stop && stall[4] == NoStop) begin
            ex_to_mem_bus_r <= '0;
            state           <= FRESH;
        end else if (stall[3] == NoStop) begin
            ex_to_mem_bus_r <= ex_to_mem_bus;
            state           <= FRESH;
        end else if (state == FRESH) begin
            // First held edge: the SRAM data is still valid, later edges it may not be.
            rdata_hold <= data_sram_rdata;
            state      <= HELD;
        end
    end

    assign rdata = (state == HELD) ? rdata_hold : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
    load_align u_load_align (
        .mem_op (ex_to_mem_bus_r.mem_op),
        .addr   (ex_to_mem_bus_r.ex_result[1:0]),
        .rdata  (rdata),
        .data   (load_data)
    );
    logic unused_fields;
    assign unused_fields = ^{stall, ex_to_mem_bus_r.data_ram_en, ex_to_mem_bus_r.data_ram_wen};
`else
    assign load_data = rdata;
    logic unused_fields;
    assign unused_fields = ^{stall, ex_to_mem_bus_r.data_ram_en, ex_to_mem_bus_r.data_ram_wen,
                             ex_to_mem_bus_r.mem_op};
`endif

    assign rf_wdata = ex_to_mem_bus_r.sel_rf_res ? load_data : ex_to_mem_bus_r.ex_result;

    assign mem_to_wb_bus = {
        ex_to_mem_bus_r.lo_we,
        ex_to_mem_bus_r.lo_wdata,
        ex_to_mem_bus_r.hi_we,
        ex_to_mem_bus_r.hi_wdata,
        ex_to_mem_bus_r.pc,
        ex_to_mem_bus_r.rf_we,
        ex_to_mem_bus_r.rf_waddr,
        rf_wdata
    };

    assign mem_to_id_fwd = {ex_to_mem_bus_r.rf_we, ex_to_mem_bus_r.rf_waddr, rf_wdata};

endmodule
